// File: rtl/btn_debounce_array.sv
// Multi-channel push-button conditioner: 2-FF sync, sampled stability filter, press/release strobes.
// Optional auto-repeat of PRESS while held, enabled by defining BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce_array #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CLK_HZ     = 125000000,
  parameter int unsigned SAMPLE_HZ  = 1000,
  parameter int unsigned STABLE     = 4,
  parameter int unsigned REP_DELAY  = 500,
  parameter int unsigned REP_PERIOD = 100
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] BTNIN,
  output logic [NCH-1:0] BTNOUT,
  output logic [NCH-1:0] PRESS,
  output logic [NCH-1:0] RELEASE,
  output logic           TICK
);

  localparam int unsigned DIV     = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned PW      = $clog2(DIV);
  localparam int unsigned CW      = $clog2(STABLE + 1);
  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic [PW-1:0]          pre_cnt;
  logic [NCH-1:0]         sync1, s;
  logic [NCH-1:0][CW-1:0] cnt, cnt_nxt;
  logic [NCH-1:0][RW-1:0] rcnt, rcnt_nxt;
  logic [NCH-1:0]         rphase, rphase_nxt;
  logic [NCH-1:0]         btn_nxt, rise_c, fall_c, rep_c;

  // Prescaler: TICK is high for the one cycle following count DIV-1
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt <= '0;
      TICK    <= 1'b0;
    end else if (pre_cnt == PW'(DIV - 1)) begin
      pre_cnt <= '0;
      TICK    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
      TICK    <= 1'b0;
    end
  end

  // Per-channel stability filter and (optionally) repeat counter
  always_comb begin
    cnt_nxt    = cnt;
    btn_nxt    = BTNOUT;
    rise_c     = '0;
    fall_c     = '0;
    rep_c      = '0;
    rcnt_nxt   = rcnt;
    rphase_nxt = rphase;
    for (int i = 0; i < int'(NCH); i++) begin
      if (TICK) begin
        if (s[i] == BTNOUT[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CW'(STABLE - 1)) begin
          cnt_nxt[i] = '0;
          btn_nxt[i] = s[i];
          rise_c[i]  = s[i];
          fall_c[i]  = ~s[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
      // Repeat counter only runs while the committed level is high; a release tick suppresses it
      if (!REP_EN || !BTNOUT[i]) begin
        rcnt_nxt[i]   = '0;
        rphase_nxt[i] = 1'b0;
      end else if (TICK && !fall_c[i]) begin
        if (rcnt[i] == (rphase[i] ? RW'(REP_PERIOD - 1) : RW'(REP_DELAY - 1))) begin
          rep_c[i]      = 1'b1;
          rcnt_nxt[i]   = '0;
          rphase_nxt[i] = 1'b1;
        end else begin
          rcnt_nxt[i] = rcnt[i] + RW'(1);
        end
      end
    end
  end

  // Synchroniser, filter state and registered strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1   <= '0;
      s       <= '0;
      cnt     <= '0;
      rcnt    <= '0;
      rphase  <= '0;
      BTNOUT  <= '0;
      PRESS   <= '0;
      RELEASE <= '0;
    end else begin
      sync1   <= BTNIN;
      s       <= sync1;
      cnt     <= cnt_nxt;
      rcnt    <= rcnt_nxt;
      rphase  <= rphase_nxt;
      BTNOUT  <= btn_nxt;
      PRESS   <= rise_c | rep_c;
      RELEASE <= fall_c;
    end
  end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed self-checking bench for btn_debounce_array (NCH=4, DIV=10, STABLE=3, repeat 5/2).
module tb_btn_debounce_array;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] BTNIN;
  logic [3:0] BTNOUT, PRESS, RELEASE;
  logic       TICK;

  int checks = 0;
  int errors = 0;
  int hit, acc, acc2, np, tk;
  int off [3];

  always #5 CLK = ~CLK;

  btn_debounce_array #(
    .NCH(4), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE(3), .REP_DELAY(5), .REP_PERIOD(2)
  ) dut (
    .CLK(CLK), .RST(RST), .BTNIN(BTNIN), .BTNOUT(BTNOUT),
    .PRESS(PRESS), .RELEASE(RELEASE), .TICK(TICK)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with all buttons pressed
    RST = 1'b1;
    BTNIN = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_outputs", 32'({BTNOUT, PRESS, RELEASE, TICK}), 32'd0);
    end
    RST = 1'b0;
    BTNIN = 4'h0;
    acc = 0;
    for (int n = 1; n < 10; n++) begin
      step();
      if (TICK) acc++;
    end
    chk("tick_before_10", 32'(acc), 32'd0);
    step();
    chk("tick_at_10", 32'(TICK), 32'd1);

    // Clean press on channel 0
    BTNIN[0] = 1'b1;
    hit = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (BTNOUT[0]) begin
        hit = n;
        break;
      end
    end
    chk("press_latency_in_range", 32'(hit >= 23 && hit <= 32), 32'd1);
    chk("press_strobe_at_commit", 32'(PRESS), 32'b0001);
    chk("release_quiet_at_commit", 32'(RELEASE), 32'd0);
    step();
    chk("press_strobe_one_cycle", 32'(PRESS[0]), 32'd0);
    acc = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (BTNOUT[3:1] != 3'b0 || PRESS[3:1] != 3'b0 || RELEASE != 4'b0) acc++;
    end
    chk("idle_channels_low", 32'(acc), 32'd0);

    // Glitch on channel 1
    acc = 0;
    BTNIN[1] = 1'b1;
    for (int n = 0; n < 15; n++) begin
      step();
      if (BTNOUT[1] || PRESS[1] || RELEASE[1]) acc++;
    end
    BTNIN[1] = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (BTNOUT[1] || PRESS[1] || RELEASE[1]) acc++;
    end
    chk("glitch_filtered", 32'(acc), 32'd0);
    chk("glitch_ch0_held", 32'(BTNOUT[0]), 32'd1);

    // Simultaneous release on 0 and press on 2
    BTNIN[0] = 1'b0;
    BTNIN[2] = 1'b1;
    hit = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (RELEASE[0]) begin
        hit = n;
        break;
      end
    end
    chk("sim_release_latency", 32'(hit >= 23 && hit <= 32), 32'd1);
    chk("sim_strobes_together", 32'({PRESS[2], RELEASE[0]}), 32'b11);
    step();
    chk("sim_btnout", 32'(BTNOUT), 32'b0100);
    chk("sim_strobes_clear", 32'({PRESS[2], RELEASE[0]}), 32'd0);

    // Reset after two ticks of a pending change on channel 3
    BTNIN[3] = 1'b1;
    tk = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (TICK) begin
        tk++;
        if (tk == 2) break;
      end
    end
    chk("two_ticks_seen", 32'(tk), 32'd2);
    chk("pre_reset_no_commit", 32'(BTNOUT[3]), 32'd0);
    RST = 1'b1;
    step();
    chk("midreset_outputs", 32'({BTNOUT, PRESS, RELEASE, TICK}), 32'd0);
    RST = 1'b0;
    hit = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (BTNOUT[3]) begin
        hit = n;
        break;
      end
    end
    chk("rst_midcount_latency", 32'(hit), 32'd31);
    chk("rst_midcount_press", 32'(PRESS), 32'b1100);

    // Auto-repeat on channel 0
    BTNIN = 4'h0;
    for (int n = 0; n < 40; n++) step();
    chk("all_released", 32'(BTNOUT), 32'd0);
    BTNIN[0] = 1'b1;
    hit = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (PRESS[0]) begin
        hit = n;
        break;
      end
    end
    chk("repeat_commit_seen", 32'(hit > 0 && BTNOUT[0]), 32'd1);
    np = 0;
    off[0] = -1;
    off[1] = -1;
    off[2] = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (PRESS[0]) begin
        if (np < 3) off[np] = k;
        np++;
      end
    end
`ifdef BTN_DEBOUNCE_REPEAT_EN
    chk("repeat_count", 32'(np), 32'd3);
    chk("repeat_first", 32'(off[0]), 32'd50);
    chk("repeat_second", 32'(off[1]), 32'd70);
    chk("repeat_third", 32'(off[2]), 32'd90);
`else
    chk("no_repeat_count", 32'(np), 32'd0);
`endif
    BTNIN[0] = 1'b0;
    acc = 0;
    acc2 = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (RELEASE[0]) begin
        acc++;
        if (PRESS[0]) acc2++;
      end
    end
    chk("final_release_once", 32'(acc), 32'd1);
    chk("release_no_press_overlap", 32'(acc2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_array.md
# btn_debounce_array

Parametrised multi-channel push-button conditioner, successor to the single-channel debouncer. Each channel is synchronised into CLK, sampled at a programmable rate, and committed to a new level only after a programmable number of consecutive agreeing samples. Each channel provides a clean level plus one-cycle press and release strobes. An optional auto-repeat generates periodic press strobes while a button is held. The block sits between the board button pins and the user-logic FSMs.

## Interface
- NCH, 4: number of independent button channels (≥1)
- CLK_HZ, 125000000: CLK frequency in Hz
- SAMPLE_HZ, 1000: sample-strobe rate in Hz; DIV = CLK_HZ/SAMPLE_HZ, must be ≥2
- STABLE, 4: consecutive differing samples required to commit a change (≥1)
- REP_DELAY, 500: samples from commit-to-1 until the first repeat strobe (used only with the macro, ≥1)
- REP_PERIOD, 100: samples between subsequent repeat strobes (used only with the macro, ≥1)

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- BTNIN  in  NCH  raw asynchronous button inputs, active-high
- BTNOUT  out  NCH  debounced level
- PRESS  out  NCH  one-cycle strobe on a 0→1 commit, and on repeats when enabled
- RELEASE  out  NCH  one-cycle strobe on a 1→0 commit
- TICK  out  1  sample strobe, one cycle every DIV cycles

## Operation
- **Prescaler:** a counter of width $clog2(DIV) counts 0..DIV-1 and then wraps to 0. TICK is registered high in the cycle after the count reaches DIV-1, giving exactly one high cycle per DIV cycles.
- **Synchroniser:** each channel passes through two flip-flops. The second flip-flop output is `s[i]`.
- **Per-channel stability counter** (width $clog2(STABLE+1)), evaluated only when TICK=1:
  - If `s[i]`==BTNOUT[i], the counter clears to 0.
  - Otherwise, if counter==STABLE-1, then BTNOUT[i]<=`s[i]` and the counter clears. Otherwise the counter increments.
- **Press and release strobes:**
  - PRESS[i] is registered high in the same edge that sets BTNOUT[i] 0→1.
  - RELEASE[i] is registered high in the same edge that clears BTNOUT[i] 1→0.
  - Both strobes are low in all other cycles.
- **Channel independence:** channels are fully independent. Any combination of channels may commit in the same cycle, and strobes assert together.
- **Glitch filtering:** a glitch shorter than (STABLE-1)·DIV cycles never changes BTNOUT.

## Timing
- **Reset values:** all outputs are 0. The prescaler, synchronisers, stability counters and repeat counters are all 0.
- **RST priority:** RST has priority over every other event. Asserting RST mid-count discards partial counts. The first TICK after release is DIV cycles later.
- **Latency:** a step on BTNIN held steady reaches BTNOUT between (STABLE-1)·DIV+3 and STABLE·DIV+2 cycles later. The bound depends on the phase relative to TICK.
- **Counter wrap:** the prescaler and repeat counters wrap without a lost or double TICK.
- **Input during a sample:** BTNIN changing in the same cycle as TICK has no effect on that sample, because of the two-cycle synchroniser delay.

## Configuration
- **Macro:** BTN_DEBOUNCE_REPEAT_EN.
- **Defined:** a per-channel repeat counter of width $clog2(max(REP_DELAY,REP_PERIOD)+1) counts TICKs while BTNOUT[i]=1. It clears on the press commit, and is held at 0 while BTNOUT[i]=0.
  - After REP_DELAY ticks it pulses PRESS[i] for one cycle and reloads to count REP_PERIOD.
  - It then pulses again every REP_PERIOD ticks until release.
  - A repeat strobe never coincides with RELEASE.
- **Undefined:** the repeat logic is absent, REP_DELAY and REP_PERIOD are ignored, and PRESS strobes only on commit.

## Test plan
All tests use NCH=4, CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10) and STABLE=3.
- **Reset:** hold RST for 5 cycles with BTNIN=4'hF. BTNOUT, PRESS, RELEASE and TICK are all 0 during reset. TICK first rises 10 cycles after RST falls.
- **Clean press:** BTNIN[0] goes 0→1 and is held for 100 cycles. BTNOUT[0] rises 23–32 cycles after the edge, and PRESS[0] is high for exactly that one cycle. Channels 1–3 stay 0.
- **Glitch:** apply a 15-cycle high pulse on BTNIN[1], then hold it low for 60 cycles. BTNOUT[1], PRESS[1] and RELEASE[1] stay 0 throughout.
- **Simultaneous:** with BTNOUT[0]=1 and BTNOUT[2]=0, drop BTNIN[0] and raise BTNIN[2] in the same cycle. RELEASE[0] and PRESS[2] pulse in the same cycle.
- **Reset mid-count:** raise BTNIN[3] and assert RST for 1 cycle after 2 ticks. BTNOUT[3] commits only after 3 full ticks following reset release, between cycles 23 and 32.
- **Auto-repeat:** with BTN_DEBOUNCE_REPEAT_EN defined, REP_DELAY=5 and REP_PERIOD=2, hold BTNIN[0] high.
  - PRESS[0] pulses at the commit, again 50 cycles later, then every 20 cycles until release.
  - Without the macro, only the commit pulse occurs.
